// File: rtl/uart_ctrl_pkg.sv
// rtl/uart_ctrl_pkg.sv - shared types and constants for the UART control path
package uart_ctrl_pkg;

  localparam int BYTE_W = 8;

  // Baud prescale shared by the transmitter and the RX block.
  localparam int CLK_HZ   = 50_000_000;
  localparam int BAUD     = 115_200;
  localparam int BAUD_DIV = (CLK_HZ + BAUD / 2) / BAUD;

  typedef enum logic [1:0] {
    ST_ARB  = 2'd0,
    ST_LOAD = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick: first request at or after the pointer
module rr_arbiter #(
  parameter int N_REQ = 4,
  localparam int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_gnt,
  output logic [PTR_W-1:0] o_gnt_idx
);

  logic [PTR_W:0]   w_sum;
  logic [PTR_W-1:0] w_idx;

  // Scan from the farthest slot back to the pointer so the nearest request wins.
  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = '0;
    w_sum     = '0;
    w_idx     = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_sum = {1'b0, i_ptr} + (PTR_W + 1)'(k);
      if (w_sum >= (PTR_W + 1)'(N_REQ)) begin
        w_sum = w_sum - (PTR_W + 1)'(N_REQ);
      end
      w_idx = w_sum[PTR_W-1:0];
      if (i_req[w_idx]) begin
        o_gnt        = '0;
        o_gnt[w_idx] = 1'b1;
        o_gnt_idx    = w_idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - packet-granular round-robin sharing of one 8N1 UART transmitter
module uart_tx_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [N_REQ-1:0]        i_req,
  input  logic [BYTE_W*N_REQ-1:0] i_req_data,
  input  logic [N_REQ-1:0]        i_req_last,
  output logic [N_REQ-1:0]        o_ack,
  output logic [N_REQ-1:0]        o_grant,
  output logic                    o_tx_start,
  output logic [BYTE_W-1:0]       o_tx_data,
  input  logic                    i_tx_busy,
  output logic                    o_err
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

  state_t           r_state;
  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] r_owner;
  logic             r_last;
  logic [CNT_W-1:0] r_cnt;

  logic [N_REQ-1:0]  w_arb_gnt;
  logic [PTR_W-1:0]  w_arb_idx;
  logic [PTR_W-1:0]  w_next_ptr;
  logic [BYTE_W-1:0] w_arb_byte;
  logic [BYTE_W-1:0] w_owner_byte;
  logic [CNT_W-1:0]  w_cnt_inc;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .i_req     (i_req),
    .i_ptr     (r_ptr),
    .o_gnt     (w_arb_gnt),
    .o_gnt_idx (w_arb_idx)
  );

  assign w_arb_byte   = i_req_data[BYTE_W*w_arb_idx +: BYTE_W];
  assign w_owner_byte = i_req_data[BYTE_W*r_owner +: BYTE_W];
  assign w_next_ptr   = (r_owner == PTR_W'(N_REQ - 1)) ? '0 : r_owner + PTR_W'(1);
  assign w_cnt_inc    = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);

  // Release (normal or aborted) always advances the pointer past the owner.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_ARB;
      r_ptr      <= '0;
      r_owner    <= '0;
      r_last     <= 1'b0;
      r_cnt      <= '0;
      o_ack      <= '0;
      o_grant    <= '0;
      o_tx_start <= 1'b0;
      o_tx_data  <= '0;
      o_err      <= 1'b0;
    end else begin
      o_ack <= '0;
      o_err <= 1'b0;
      case (r_state)
        ST_ARB: begin
          if (!i_tx_busy && |i_req) begin
            r_owner    <= w_arb_idx;
            o_grant    <= w_arb_gnt;
            o_tx_data  <= w_arb_byte;
            o_tx_start <= 1'b1;
            r_cnt      <= '0;
            r_state    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (i_tx_busy) begin
            o_tx_start <= 1'b0;
            o_ack      <= o_grant;
            r_last     <= i_req_last[r_owner];
            r_cnt      <= '0;
            r_state    <= ST_WAIT;
          end else if (r_cnt == CNT_LAST) begin
            o_tx_start <= 1'b0;
            o_err      <= 1'b1;
            o_grant    <= '0;
            r_ptr      <= w_next_ptr;
            r_cnt      <= '0;
            r_state    <= ST_ARB;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        ST_WAIT: begin
          if (i_tx_busy) begin
            r_cnt <= '0;
          end else if (r_last) begin
            o_grant <= '0;
            r_ptr   <= w_next_ptr;
            r_cnt   <= '0;
            r_state <= ST_ARB;
          end else if (i_req[r_owner]) begin
            o_tx_data  <= w_owner_byte;
            o_tx_start <= 1'b1;
            r_cnt      <= '0;
            r_state    <= ST_LOAD;
          end else if (r_cnt == CNT_LAST) begin
            o_err   <= 1'b1;
            o_grant <= '0;
            r_ptr   <= w_next_ptr;
            r_cnt   <= '0;
            r_state <= ST_ARB;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
        default: r_state <= ST_ARB;
      endcase
    end
  end

endmodule
